// File: rtl/st_commit_ctrl_pkg.sv
// Shared definitions for the store commit controller: station tag map,
// datapath widths and the commit FSM state encoding.
package st_commit_ctrl_pkg;

  localparam int TAG_W  = 4;
  localparam int DATA_W = 64;

  // Reservation-station tag map; tag 0 means "no entry".
  localparam logic [TAG_W-1:0] NOTAG    = 4'd0;
  localparam logic [TAG_W-1:0] ALU_TAG1 = 4'd1;
  localparam logic [TAG_W-1:0] ALU_TAG2 = 4'd2;
  localparam logic [TAG_W-1:0] ALU_TAG3 = 4'd3;
  localparam logic [TAG_W-1:0] ALU_TAG4 = 4'd4;
  localparam logic [TAG_W-1:0] MUL_TAG1 = 4'd5;
  localparam logic [TAG_W-1:0] MUL_TAG2 = 4'd6;
  localparam logic [TAG_W-1:0] LD_TAG1  = 4'd7;
  localparam logic [TAG_W-1:0] LD_TAG2  = 4'd8;
  localparam logic [TAG_W-1:0] ST_TAG1  = 4'd9;
  localparam logic [TAG_W-1:0] ST_TAG2  = 4'd10;

  // Commit sequence: wait for ready head, hold the write, release the entry.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_FREE = 2'd2
  } st_state_t;

endpackage

// File: rtl/tag_order_fifo.sv
// Two-deep FIFO of station tags recording store allocation order.
// Entry 0 is always the oldest; a pop shifts entry 1 down.
module tag_order_fifo #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output logic [TAG_W-1:0] head_tag,
  output logic [1:0]       count,
  output logic             full,
  output logic             empty
);

  logic [TAG_W-1:0] slot_reg [2];
  logic [1:0]       count_reg;
  logic             pop_ok;
  logic             push_ok;

  // A pop frees a place, so a push into a full FIFO is legal in the same cycle.
  assign pop_ok   = pop && (count_reg != 2'd0);
  assign push_ok  = push && ((count_reg != 2'd2) || pop_ok);
  assign head_tag = slot_reg[0];
  assign count    = count_reg;
  assign full     = (count_reg == 2'd2);
  assign empty    = (count_reg == 2'd0);

  // Shift-register storage: push lands behind the survivors of any pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg   <= 2'd0;
      slot_reg[0] <= '0;
      slot_reg[1] <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          slot_reg[count_reg[0]] <= push_tag;
          count_reg              <= count_reg + 2'd1;
        end
        2'b01: begin
          slot_reg[0] <= slot_reg[1];
          count_reg   <= count_reg - 2'd1;
        end
        2'b11: begin
          if (count_reg == 2'd2) begin
            slot_reg[0] <= slot_reg[1];
            slot_reg[1] <= push_tag;
          end else begin
            slot_reg[0] <= push_tag;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/st_commit_ctrl.sv
// Store commit controller: services the oldest store of the two-entry store
// station, computes base+offset, runs the req/ack memory write and frees the
// station entry with a one-cycle pulse.
module st_commit_ctrl #(
  parameter int               TAG_W   = st_commit_ctrl_pkg::TAG_W,
  parameter int               DATA_W  = st_commit_ctrl_pkg::DATA_W,
  parameter logic [TAG_W-1:0] ST_TAG1 = st_commit_ctrl_pkg::ST_TAG1,
  parameter logic [TAG_W-1:0] ST_TAG2 = st_commit_ctrl_pkg::ST_TAG2,
  parameter logic [TAG_W-1:0] NOTAG   = st_commit_ctrl_pkg::NOTAG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc,
  input  logic [TAG_W-1:0]  alloc_tag,
  input  logic              st_aff_ready,
  input  logic [DATA_W-1:0] st_affinity_op,
  input  logic [DATA_W-1:0] st_affinity_offset,
  input  logic [2*DATA_W-1:0] st_data,
  input  logic              mem_ack,
  output logic [TAG_W-1:0]  query_tag,
  output logic [DATA_W-1:0] address,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              free_tag_flag,
  output logic [TAG_W-1:0]  free_this_tag,
  output logic              order_err,
  output logic [15:0]       stores_done
);

  import st_commit_ctrl_pkg::*;

  st_state_t         state_reg, state_next;
  logic [TAG_W-1:0]  head_tag;
  logic [1:0]        q_count;
  logic              q_full, q_empty;
  logic              push, pop, store_tag;
  logic              launch, ack_take;
  logic [DATA_W-1:0] head_data;

  logic              mem_req_reg;
  logic [DATA_W-1:0] mem_addr_reg, mem_wdata_reg;
  logic              free_flag_reg;
  logic [TAG_W-1:0]  free_tag_reg;
  logic              order_err_reg;
  logic [15:0]       done_reg;

  // Only the two store tags may enter the order queue.
  assign store_tag = (alloc_tag == ST_TAG1) || (alloc_tag == ST_TAG2);
  assign pop       = (state_reg == ST_FREE);
  assign push      = alloc && store_tag && (!q_full || pop);
  assign address   = st_affinity_op + st_affinity_offset;
  assign head_data = (head_tag == ST_TAG2) ? st_data[2*DATA_W-1:DATA_W]
                                           : st_data[DATA_W-1:0];

  tag_order_fifo #(.TAG_W(TAG_W)) u_order (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_tag (alloc_tag),
    .pop      (pop),
    .head_tag (head_tag),
    .count    (q_count),
    .full     (q_full),
    .empty    (q_empty)
  );

  // Next-state and query logic; the head is only offered to the station in IDLE.
  always_comb begin
    state_next = state_reg;
    query_tag  = NOTAG;
    launch     = 1'b0;
    ack_take   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!q_empty) query_tag = head_tag;
        if ((q_count != 2'd0) && st_aff_ready) begin
          launch     = 1'b1;
          state_next = ST_MEM;
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          ack_take   = 1'b1;
          state_next = ST_FREE;
        end
      end
      ST_FREE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Write-port, free-pulse, error and completion registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_reg   <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      free_flag_reg <= 1'b0;
      free_tag_reg  <= NOTAG;
      order_err_reg <= 1'b0;
      done_reg      <= 16'd0;
    end else begin
      if (alloc && !push) order_err_reg <= 1'b1;
      if (launch) begin
        mem_req_reg   <= 1'b1;
        mem_addr_reg  <= address;
        mem_wdata_reg <= head_data;
      end
      if (ack_take) begin
        mem_req_reg   <= 1'b0;
        free_flag_reg <= 1'b1;
        free_tag_reg  <= head_tag;
      end
      if (pop) begin
        free_flag_reg <= 1'b0;
        free_tag_reg  <= NOTAG;
        done_reg      <= done_reg + 16'd1;
      end
    end
  end

  assign mem_req       = mem_req_reg;
  assign mem_addr      = mem_addr_reg;
  assign mem_wdata     = mem_wdata_reg;
  assign free_tag_flag = free_flag_reg;
  assign free_this_tag = free_tag_reg;
  assign order_err     = order_err_reg;
  assign stores_done   = done_reg;

endmodule
